// File: rtl/rect_drawer.sv
// Raster-order rectangle pixel source for the VGA mux, with clipping and stall hold.
// Optional erase-before-draw pass of the previous rectangle: define RECT_DRAWER_ERASE_EN.
module rect_drawer #(
  parameter int         DIM_W    = 5,
  parameter int         SCREEN_W = 160,
  parameter int         SCREEN_H = 120,
  parameter logic [2:0] BG_COLOR = 3'b000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       x_in,
  input  logic [6:0]       y_in,
  input  logic [DIM_W-1:0] w_in,
  input  logic [DIM_W-1:0] h_in,
  input  logic [2:0]       color_in,
  input  logic             stall,
  output logic [7:0]       x_out,
  output logic [6:0]       y_out,
  output logic [2:0]       color_out,
  output logic             plot,
  output logic             busy,
  output logic             done
);

`ifdef RECT_DRAWER_ERASE_EN
  typedef enum logic [1:0] {IDLE, ERASE, DRAW, FINISH} state_t;
`else
  typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;
`endif

  localparam logic [8:0]       X_LIM = SCREEN_W[8:0];
  localparam logic [7:0]       Y_LIM = SCREEN_H[7:0];
  localparam logic [DIM_W-1:0] ONE   = 1;

  state_t state, next_state;

  logic [7:0]       x_r, last_x;
  logic [6:0]       y_r, last_y;
  logic [DIM_W-1:0] w_r, h_r, cx, cy;
  logic [2:0]       color_r, last_color;

  logic             erasing, walking, visible, advance;
  logic             col_last, row_last, last_pix, new_empty;
  logic [7:0]       walk_x;
  logic [6:0]       walk_y;
  logic [DIM_W-1:0] walk_w, walk_h;
  logic [2:0]       walk_color;
  logic [8:0]       sx;
  logic [7:0]       sy;

`ifdef RECT_DRAWER_ERASE_EN
  logic [7:0]       px;
  logic [6:0]       py;
  logic [DIM_W-1:0] pw, ph;
  logic             have_prev;

  assign erasing = (state == ERASE);
  assign walk_x  = erasing ? px : x_r;
  assign walk_y  = erasing ? py : y_r;
  assign walk_w  = erasing ? pw : w_r;
  assign walk_h  = erasing ? ph : h_r;
`else
  assign erasing = 1'b0;
  assign walk_x  = x_r;
  assign walk_y  = y_r;
  assign walk_w  = w_r;
  assign walk_h  = h_r;
`endif

  assign walking    = (state == DRAW) || erasing;
  assign walk_color = erasing ? BG_COLOR : color_r;
  // One bit wider than the coordinate so off-screen sums never wrap back on screen.
  assign sx         = {1'b0, walk_x} + 9'(cx);
  assign sy         = {1'b0, walk_y} + 8'(cy);
  assign visible    = (sx < X_LIM) && (sy < Y_LIM);
  assign advance    = walking && (!visible || !stall);
  assign col_last   = (cx == walk_w - ONE);
  assign row_last   = (cy == walk_h - ONE);
  assign last_pix   = col_last && row_last;
  assign new_empty  = (w_r == '0) || (h_r == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    plot       = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    x_out      = last_x;
    y_out      = last_y;
    color_out  = last_color;
    if (walking) begin
      plot      = visible;
      x_out     = sx[7:0];
      y_out     = sy[6:0];
      color_out = walk_color;
    end
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
`ifdef RECT_DRAWER_ERASE_EN
          if (have_prev)                        next_state = ERASE;
          else
`endif
          if ((w_in == '0) || (h_in == '0))     next_state = FINISH;
          else                                  next_state = DRAW;
        end
      end
`ifdef RECT_DRAWER_ERASE_EN
      ERASE:  if (advance && last_pix) next_state = new_empty ? FINISH : DRAW;
`endif
      DRAW:   if (advance && last_pix) next_state = FINISH;
      FINISH: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_r <= '0; y_r <= '0; w_r <= '0; h_r <= '0; color_r <= '0;
      cx <= '0; cy <= '0;
      last_x <= '0; last_y <= '0; last_color <= '0;
`ifdef RECT_DRAWER_ERASE_EN
      px <= '0; py <= '0; pw <= '0; ph <= '0; have_prev <= 1'b0;
`endif
    end else begin
      if (state == IDLE && start) begin
        x_r <= x_in; y_r <= y_in; w_r <= w_in; h_r <= h_in; color_r <= color_in;
        cx  <= '0;   cy  <= '0;
      end
      if (walking) begin
        last_x <= sx[7:0]; last_y <= sy[6:0]; last_color <= walk_color;
      end
      if (advance) begin
        if (last_pix) begin
          cx <= '0; cy <= '0;
        end else if (col_last) begin
          cx <= '0; cy <= cy + ONE;
        end else begin
          cx <= cx + ONE;
        end
      end
`ifdef RECT_DRAWER_ERASE_EN
      if (state == DRAW && advance && last_pix) begin
        px <= x_r; py <= y_r; pw <= w_r; ph <= h_r; have_prev <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rect_drawer.sv
// Scoreboard bench for rect_drawer: a pass-level model predicts pixels and done timing.
module tb_rect_drawer;
  localparam int DIM_W = 5;

  logic             clk = 1'b0;
  logic             reset, start, stall;
  logic [7:0]       x_in;
  logic [6:0]       y_in;
  logic [DIM_W-1:0] w_in, h_in;
  logic [2:0]       color_in;
  logic [7:0]       x_out;
  logic [6:0]       y_out;
  logic [2:0]       color_out;
  logic             plot, busy, done;

  rect_drawer #(.DIM_W(DIM_W)) dut (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
    .w_in(w_in), .h_in(h_in), .color_in(color_in), .stall(stall),
    .x_out(x_out), .y_out(y_out), .color_out(color_out),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [17:0] exp_q[$];
  int          vis_q[$];
  logic [17:0] mon_e;
  logic [17:0] prev_pix;
  logic        prev_hold = 1'b0;
  bit          have_prev = 1'b0;
  int          px, py, pw, ph;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every accepted pixel is popped from the scoreboard; held pixels must not move.
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold)
        check("stall_hold", 32'({plot, x_out, y_out, color_out}), 32'({1'b1, prev_pix}));
      if (plot && !stall) begin
        check("pixel_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("pixel", 32'({x_out, y_out, color_out}), 32'(mon_e));
        end
      end
      prev_hold = plot && stall;
      prev_pix  = {x_out, y_out, color_out};
    end
  end

  task automatic add_pass(input int x, input int y, input int w, input int h, input int c);
    for (int r = 0; r < h; r++)
      for (int col = 0; col < w; col++) begin
        if ((x + col) < 160 && (y + r) < 120) begin
          vis_q.push_back(1);
          exp_q.push_back({8'(x + col), 7'(y + r), 3'(c)});
        end else begin
          vis_q.push_back(0);
        end
      end
  endtask

  // Predicts the pixel list and the cycle (1 = first after accept) on which done pulses.
  task automatic model(input int x, input int y, input int w, input int h, input int c,
                       input logic [255:0] sb, output int d);
    int k, idx;
    vis_q.delete();
`ifdef RECT_DRAWER_ERASE_EN
    if (have_prev) add_pass(px, py, pw, ph, 0);
    if (w > 0 && h > 0) begin
      have_prev = 1'b1; px = x; py = y; pw = w; ph = h;
    end
`endif
    add_pass(x, y, w, h, c);
    k = 1; idx = 0;
    while (idx < vis_q.size()) begin
      if (vis_q[idx] != 0 && k < 256 && sb[k]) k++;
      else begin idx++; k++; end
    end
    d = k;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stall = 1'b0;
    x_in = '0; y_in = '0; w_in = '0; h_in = '0; color_in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    have_prev = 1'b0;
    @(negedge clk);
    check("reset_outputs", 32'({x_out, y_out, color_out, plot, busy, done}), 32'd0);
  endtask

  task automatic run_req(input int x, input int y, input int w, input int h, input int c,
                         input logic [255:0] sb, input bit spurious);
    int d;
    @(posedge clk); #1;
    x_in = 8'(x); y_in = 7'(y); w_in = DIM_W'(w); h_in = DIM_W'(h); color_in = 3'(c);
    start = 1'b1; stall = 1'b0;
    model(x, y, w, h, c, sb, d);
    @(posedge clk); #1;
    for (int k = 1; k <= d + 1; k++) begin
      stall = (k <= d && k < 256) ? sb[k] : 1'b0;
      if (spurious && ((k == 3 && k < d) || k == d)) begin
        start = 1'b1; x_in = 8'($urandom); y_in = 7'($urandom);
        w_in = DIM_W'($urandom_range(1, 3)); h_in = DIM_W'($urandom_range(1, 3));
        color_in = 3'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (k < d)       check("busy_walking", 32'({busy, done}), 32'd2);
      else if (k == d) check("done_pulse", 32'({busy, done, plot}), 32'd6);
      else             check("idle_after", 32'({busy, done}), 32'd0);
      @(posedge clk); #1;
    end
    start = 1'b0; stall = 1'b0;
    check("all_pixels_out", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [255:0] sb;
    int d;

    do_reset();

    sb = '0;
    run_req(10, 20, 3, 2, 5, sb, 1'b0);
    for (int i = 2; i <= 5; i++) sb[i] = 1'b1;
    run_req(10, 20, 3, 2, 5, sb, 1'b0);
    sb = '0;
    run_req(158, 119, 4, 2, 3, sb, 1'b0);
    run_req(0, 0, 0, 5, 7, sb, 1'b0);
    run_req(50, 60, 4, 4, 1, sb, 1'b1);

    // Reset lands while the third pixel of a 4x4 is on the bus.
    @(posedge clk); #1;
    x_in = 8'd20; y_in = 7'd30; w_in = 5'd4; h_in = 5'd4; color_in = 3'd6; start = 1'b1;
    model(20, 30, 4, 4, 6, sb, d);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("mid_reset_outputs", 32'({x_out, y_out, color_out, plot, busy, done}), 32'd0);
    check("mid_reset_emitted", 32'(exp_q.size()), 32'd14);
    exp_q.delete();
    have_prev = 1'b0;
    run_req(100, 100, 1, 1, 2, sb, 1'b0);

`ifdef RECT_DRAWER_ERASE_EN
    do_reset();
    run_req(5, 5, 2, 1, 2, sb, 1'b0);
    run_req(40, 40, 1, 1, 4, sb, 1'b0);
    run_req(40, 40, 0, 0, 4, sb, 1'b0);
`endif

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 256; i++) sb[i] = ($urandom_range(0, 2) == 0);
      run_req($urandom_range(0, 1) != 0 ? $urandom_range(140, 255) : $urandom_range(0, 139),
              $urandom_range(0, 1) != 0 ? $urandom_range(100, 127) : $urandom_range(0, 99),
              $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 7),
              sb, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rect_drawer.md
# rect_drawer

Pixel-stream producer that feeds the VGA output multiplexer. On a `start` request it walks an axis-aligned rectangle in raster order and presents one pixel per accepted cycle on `x_out`/`y_out`/`color_out`, qualified by `plot`. `busy` tells the multiplexer that this source owns the pixel bus, and `stall` mirrors VGA back-pressure. Player and wall renderers each instantiate one.

## Interface
- `DIM_W`, 5: width of the `w_in`/`h_in` size fields; maximum size is 2^DIM_W−1.
- `SCREEN_W`, 160: number of visible columns; pixels with x ≥ SCREEN_W are clipped.
- `SCREEN_H`, 120: number of visible rows; pixels with y ≥ SCREEN_H are clipped.
- `BG_COLOR`, 3'b000: colour used for erase passes.

- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `x_in`  in  8  top-left column.
- `y_in`  in  7  top-left row.
- `w_in`  in  DIM_W  width in pixels.
- `h_in`  in  DIM_W  height in pixels.
- `color_in`  in  3  fill colour.
- `stall`  in  1  downstream busy; while high, the presented pixel is not accepted.
- `x_out`  out  8  pixel column.
- `y_out`  out  7  pixel row.
- `color_out`  out  3  pixel colour.
- `plot`  out  1  pixel valid.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`, inclusive.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, ERASE (only with the macro), DRAW, FINISH.
- IDLE, `start`=1:
  - Register `x_in`, `y_in`, `w_in`, `h_in`, `color_in`.
  - Next state is ERASE if enabled and a previous rectangle exists; otherwise DRAW.
- `start` is ignored outside IDLE, and request inputs are not resampled.
- If `w_in`=0 or `h_in`=0: go directly to FINISH; emit no pixels.
- Walk order:
  - Column offset `cx` runs 0..w−1 fastest, then row offset `cy` runs 0..h−1.
  - `x_out` = x+cx and `y_out` = y+cy, computed one bit wider. This width covers the maximum sum (255+31 for x, 127+31 for y), so the compare is exact.
  - If the wide sum is ≥ SCREEN_W or ≥ SCREEN_H: drive `plot`=0 for that cycle and advance unconditionally. A clipped pixel does not wait on `stall`.
- Advance rule: a visible pixel advances when `plot`=1 and `stall`=0. A pixel held under `stall` keeps all outputs stable.
- After the last pixel (cx=w−1, cy=h−1) advances:
  - ERASE → DRAW, with offsets reset to 0.
  - DRAW → FINISH.
- FINISH:
  - `done`=1 and `busy`=1 for one cycle, `plot`=0.
  - Then IDLE; `busy` falls on the following cycle.
- Outside active walking: `plot`=0, and `x_out`/`y_out`/`color_out` hold their last value.
- Reset (including mid-walk):
  - State → IDLE; all outputs → 0; offsets cleared.
  - With the macro, the "previous rectangle exists" flag is cleared.

## Timing
- Start latency: `start` accepted at edge N → first pixel presented with `plot`=1 during cycle N+1, with `busy`=1.
- Throughput: one pixel per cycle with `stall`=0. An unclipped, unstalled DRAW of w×h takes w·h cycles plus one FINISH cycle.
- `stall` is sampled combinationally against the current `plot`. Pixel advance is registered, with no bubble between pixels.
- If `start` is asserted during the FINISH cycle, it is ignored. The earliest next accept is the first IDLE cycle.

## Configuration
- Macro: `RECT_DRAWER_ERASE_EN`.
- Defined:
  - After each completed DRAW, the block stores that rectangle (x, y, w, h).
  - The next request first walks the stored rectangle in `BG_COLOR` (state ERASE), with the same clipping and stall rules, then draws the new one.
  - `busy` stays high across both passes, and `done` pulses once at the end.
  - A zero-size new request still performs the erase.
- Undefined:
  - The ERASE state and the stored-rectangle registers do not exist.
  - Every request is a single DRAW pass.

## Test plan
- Basic draw: reset, then `start` with x=10, y=20, w=3, h=2, color=3'b101, `stall`=0.
  - Pixels (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), each for one cycle, colour 5.
  - `done` pulses on cycle 7 after the accept; `busy` is low on cycle 8.
- Stall: same request with `stall`=1 for 4 cycles at the second pixel.
  - (11,20) is held for 5 cycles with `plot`=1; the sequence is otherwise unchanged.
  - `done` pulses 4 cycles later than in the basic draw.
- Clipping: x=158, y=119, w=4, h=2.
  - Only (158,119) and (159,119) are plotted.
  - The other 6 cycles show `plot`=0; `done` is on cycle 9.
- Zero size and ignored start: w=0, h=5.
  - No `plot`; `done` pulses on cycle 1.
  - A second `start` issued mid-walk of a 4×4 request is ignored, and exactly 16 pixels are emitted.
- Mid-walk reset: assert `reset` on the 3rd pixel of a 4×4 request.
  - Next cycle: all outputs are 0 and the state is IDLE.
  - A new 1×1 request then plots exactly one pixel.
- Erase (macro defined): draw 2×1 at (5,5) in colour 2, then 1×1 at (40,40) in colour 4.
  - Output is (5,5) and (6,6-row-equivalent (6,5)) in colour 0, then (40,40) in colour 4.
  - Single `done`.
